// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: baud-timed receive FSM for one 8N1 UART frame. It detects the start bit,
//   samples each bit at mid-bit and checks the stop bit. A good byte is then held in a valid/ready output register.
// Latency: data/rx_valid update one cycle after the stop-bit sample, which falls about
//   2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the Rx falling edge.
// Backpressure: reception never stalls. A byte completed while rx_valid is held unconsumed overwrites data and sets the sticky overrun flag.
// Ports: clk/reset (async, active-high); Rx serial in (idle high); rx_ready consumer accept;
//   data/rx_valid received byte; frame_err stop-bit error pulse; overrun sticky; busy = not idle.
// Optional: define UART_RX_PARITY_EN to add a parity bit before the stop bit. It adds the ports
//   parity_odd (in: 0 even, 1 odd) and parity_err (out: pulse at the stop sample on mismatch).
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Rx,
  input  logic       rx_ready,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  input  logic       parity_odd,
  output logic       parity_err
`endif
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             sync1_q, sync1_d;
  logic             rx_s_q, rx_s_d;
  logic             par_ok;
`ifdef UART_RX_PARITY_EN
  logic             par_bit_q, par_bit_d;
  logic             parity_err_q, parity_err_d;

  // Total ones over data plus parity bit must match the selected parity sense.
  assign par_ok = (((^shift_q) ^ par_bit_q) == parity_odd);
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    sync1_d     = Rx;
    rx_s_d      = sync1_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif

    // Consumer handshake; a frame completing in the same cycle overrides rx_valid below.
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          // Line back high at mid start bit: a glitch, not a frame.
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d             = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          par_bit_d = rx_s_q;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          parity_err_d = !par_ok;
`endif
          if (rx_s_q) begin
            // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
            state_d = S_IDLE;
            if (par_ok) begin
              data_d     = shift_q;
              rx_valid_d = 1'b1;
              if (rx_valid_q && !rx_ready) overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_IDLE: begin
        // Ride out a break so a held-low line cannot look like a new start.
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data      = data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames are driven bit by bit, the expected
// handshake/error events are queued by a frame-level model, and a negedge monitor
// pops and compares every event the DUT presents.
module tb_uart_rx_ctrl;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] data;
  logic       rx_valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_odd = 1'b0;
  logic       parity_err;
`endif

  always #5 clk = ~clk;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .Rx(Rx), .rx_ready(rx_ready),
    .data(data), .rx_valid(rx_valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
`ifdef UART_RX_PARITY_EN
    , .parity_odd(parity_odd), .parity_err(parity_err)
`endif
  );

  int checks = 0;
  int failures = 0;

  // kind: 0 = byte handed over, 1 = frame error pulse, 2 = parity error pulse
  typedef struct {int kind; logic [7:0] dat; logic ovr;} exp_t;
  exp_t sb[$];

  // Frame-level model of the output register.
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ovr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input int kind, input string name, input logic [7:0] d, input logic o);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: event seen while none expected", name);
    end else begin
      e = sb.pop_front();
      check({name, "_kind"}, kind, e.kind);
      if (e.kind == 0 && kind == 0) begin
        check({name, "_data"}, d, e.dat);
        check({name, "_overrun"}, o, e.ovr);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) pop_chk(1, "frame_err_evt", 8'h00, 1'b0);
`ifdef UART_RX_PARITY_EN
      if (parity_err) pop_chk(2, "parity_err_evt", 8'h00, 1'b0);
`endif
      if (rx_valid && rx_ready) pop_chk(0, "handshake", data, overrun);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Parity bit that makes the frame correct for the current parity sense.
  function automatic logic good_par(input logic [7:0] b);
`ifdef UART_RX_PARITY_EN
    return (^b) ^ parity_odd;
`else
    return 1'b0;
`endif
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    logic perr;
    perr = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr = (par_bit != good_par(b));
`endif
    if (!stop_bit) sb.push_back('{kind: 1, dat: 8'h00, ovr: 1'b0});
    if (perr) sb.push_back('{kind: 2, dat: 8'h00, ovr: 1'b0});
    if (stop_bit && !perr) begin
      if (m_valid) m_ovr = 1'b1;
      m_data  = b;
      m_valid = 1'b1;
    end
    Rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      cyc(CPB);
    end
`ifdef UART_RX_PARITY_EN
    Rx = par_bit;
    cyc(CPB);
`endif
    Rx = stop_bit;
    cyc(CPB);
  endtask

  task automatic handshake();
    if (m_valid) sb.push_back('{kind: 0, dat: m_data, ovr: m_ovr});
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_rx_valid"}, rx_valid, m_valid);
    check({tag, "_data"}, data, m_data);
    check({tag, "_overrun"}, overrun, m_ovr);
  endtask

  initial begin
    logic [7:0] b;
    logic       stp;
    logic       par;

    cyc(3);
    check("reset_data", data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    check("reset_busy", busy, 1'b0);
    reset = 1'b0;
    cyc(5);

    // Single good byte held until consumed.
    send_frame(8'hA5, 1'b1, good_par(8'hA5));
    check_outputs("a5");
    check("a5_frame_err", frame_err, 1'b0);
    handshake();
    check("a5_consumed_valid", rx_valid, 1'b0);
    check("a5_data_held", data, 8'hA5);

    // False start: short low pulse.
    Rx = 1'b0;
    cyc(4);
    Rx = 1'b1;
    cyc(2);
    check("glitch_busy_during", busy, 1'b1);
    cyc(20);
    check("glitch_busy_after", busy, 1'b0);
    check_outputs("glitch");

    // Stop bit low followed by a break.
    send_frame(8'h3C, 1'b0, good_par(8'h3C));
    cyc(40);
    check("break_busy", busy, 1'b1);
    check("break_rx_valid", rx_valid, 1'b0);
    Rx = 1'b1;
    cyc(6);
    check("break_busy_after", busy, 1'b0);
    send_frame(8'h81, 1'b1, good_par(8'h81));
    check_outputs("after_break");
    handshake();

    // Back-to-back frames without consumption.
    send_frame(8'h11, 1'b1, good_par(8'h11));
    send_frame(8'h22, 1'b1, good_par(8'h22));
    check_outputs("overrun");
    handshake();
    check("overrun_cleared", overrun, 1'b0);

    // Reset in the middle of data bit 4 of 8'hFF.
    Rx = 1'b0;
    cyc(CPB);
    Rx = 1'b1;
    cyc(4 * CPB + 8);
    check("midframe_busy", busy, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_ovr   = 1'b0;
    check_outputs("async_reset");
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_frame_err", frame_err, 1'b0);
    cyc(2);
    reset = 1'b0;
    cyc(5);
    send_frame(8'h0F, 1'b1, good_par(8'h0F));
    check_outputs("after_reset");
    handshake();

`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1);
    check_outputs("par_good");
    handshake();
    send_frame(8'h07, 1'b1, 1'b0);
    check_outputs("par_bad");
    cyc(3);
`endif

    // Randomized frames, gaps, errors and consumption.
    for (int n = 0; n < 16; n++) begin
`ifdef UART_RX_PARITY_EN
      parity_odd = 1'($urandom_range(0, 1));
`endif
      b   = 8'($urandom);
      stp = ($urandom_range(0, 7) != 0);
      par = good_par(b);
      if ($urandom_range(0, 3) == 0) par = ~par;
      send_frame(b, stp, par);
      if (!stp) begin
        cyc($urandom_range(0, 30));
        Rx = 1'b1;
        cyc(4);
      end
      check_outputs("rand");
      if ($urandom_range(0, 1) == 1) handshake();
      cyc($urandom_range(0, 5));
    end
    handshake();

    cyc(5);
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
